wired_alu_arbiter: RTL and testbench

Shares one combinational wired ALU between NUM_REQ issue ports (e.g. two integer reservation stations). Each cycle it selects one valid requester round-robin and steers its operands and opcode onto the ALU. It captures the ALU result in a single output register with a valid/ready handshake, tagged with the requester's tag and source index. Sits between the issue stage and the writeback/bypass network.

---
 rtl/wired_alu_arbiter.sv | 112 +++++++++++
 tb/tb_wired_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wired_alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ issue ports.
// The ALU result is captured in a single tagged output register with a valid/ready handshake.
module wired_alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*32-1:0]    req_r0_i,
  input  logic [NUM_REQ*32-1:0]    req_r1_i,
  input  logic [NUM_REQ*32-1:0]    req_pc_i,
  input  logic [NUM_REQ*2-1:0]     req_grand_op_i,
  input  logic [NUM_REQ*2-1:0]     req_op_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic [31:0]              alu_r0_o,
  output logic [31:0]              alu_r1_o,
  output logic [31:0]              alu_pc_o,
  output logic [1:0]               alu_grand_op_o,
  output logic [1:0]               alu_op_o,
  input  logic [31:0]              alu_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [31:0]              res_o,
  output logic [TAG_W-1:0]         res_tag_o,
  output logic [SRC_W-1:0]         res_src_o
);

  localparam int PW = SRC_W + 1;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_found;
  logic [PW-1:0]    scan_idx;
  logic             can_accept;
  logic             accept;
  logic [SRC_W-1:0] next_ptr;
  logic [TAG_W-1:0] sel_tag;

  assign can_accept = ~flush_i & (~res_valid_o | res_ready_i);
  assign accept     = grant_found & can_accept;

  // Scan from rr_ptr with an explicit wrap so non-power-of-2 NUM_REQ works;
  // with no valid requester grant_idx stays at rr_ptr, which also steers the idle mux.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    scan_idx    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_idx = {1'b0, rr_ptr} + PW'(j);
      if (scan_idx >= PW'(NUM_REQ)) begin
        scan_idx = scan_idx - PW'(NUM_REQ);
      end
      if (!grant_found && req_valid_i[scan_idx[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    alu_r0_o       = req_r0_i[31:0];
    alu_r1_o       = req_r1_i[31:0];
    alu_pc_o       = req_pc_i[31:0];
    alu_grand_op_o = req_grand_op_i[1:0];
    alu_op_o       = req_op_i[1:0];
    sel_tag        = req_tag_i[TAG_W-1:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        alu_r0_o       = req_r0_i[32*i +: 32];
        alu_r1_o       = req_r1_i[32*i +: 32];
        alu_pc_o       = req_pc_i[32*i +: 32];
        alu_grand_op_o = req_grand_op_i[2*i +: 2];
        alu_op_o       = req_op_i[2*i +: 2];
        sel_tag        = req_tag_i[TAG_W*i +: TAG_W];
      end
    end
  end

  assign next_ptr = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

  // Accept overwrites the register even while draining; otherwise a drain or a
  // flush only clears valid and the data fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
      res_tag_o   <= '0;
      res_src_o   <= '0;
    end else if (accept) begin
      rr_ptr      <= next_ptr;
      res_valid_o <= 1'b1;
      res_o       <= alu_res_i;
      res_tag_o   <= sel_tag;
      res_src_o   <= grant_idx;
    end else if (flush_i || res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wired_alu_arbiter.sv
// Testbench for wired_alu_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wired_alu_arbiter;

  localparam int N     = 3;
  localparam int TAG_W = 6;
  localparam int SRC_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_i;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [N*32-1:0]    req_r0_i, req_r1_i, req_pc_i;
  logic [N*2-1:0]     req_grand_op_i, req_op_i;
  logic [N*TAG_W-1:0] req_tag_i;
  logic [31:0]        alu_r0_o, alu_r1_o, alu_pc_o;
  logic [1:0]         alu_grand_op_o, alu_op_o;
  logic [31:0]        alu_res_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [31:0]        res_o;
  logic [TAG_W-1:0]   res_tag_o;
  logic [SRC_W-1:0]   res_src_o;

  logic [N-1:0]       s_valid;
  logic [31:0]        s_r0[N], s_r1[N], s_pc[N];
  logic [1:0]         s_gop[N], s_op[N];
  logic [TAG_W-1:0]   s_tag[N];
  logic               s_flush, s_rready;

  int                 m_ptr;
  logic               m_valid;
  logic [31:0]        m_res;
  logic [TAG_W-1:0]   m_tag;
  int                 m_src;
  int                 last_acc;
  int                 fair_cnt[N];
  bit                 chk_en;
  int                 n_tests, n_fail;
  int                 cmp_k, cmp_sel;
  logic [N-1:0]       cmp_rdy;

  always #5 clk = ~clk;

  wired_alu_arbiter #(.NUM_REQ(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_r0_i(req_r0_i), .req_r1_i(req_r1_i), .req_pc_i(req_pc_i),
    .req_grand_op_i(req_grand_op_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .alu_r0_o(alu_r0_o), .alu_r1_o(alu_r1_o), .alu_pc_o(alu_pc_o),
    .alu_grand_op_o(alu_grand_op_o), .alu_op_o(alu_op_o), .alu_res_i(alu_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_tag_o(res_tag_o), .res_src_o(res_src_o)
  );

  // Stub ALU: plain add of the two operands
  assign alu_res_i = alu_r1_o + alu_r0_o;

  always_comb begin
    req_valid_i    = s_valid;
    flush_i        = s_flush;
    res_ready_i    = s_rready;
    req_r0_i       = '0;
    req_r1_i       = '0;
    req_pc_i       = '0;
    req_grand_op_i = '0;
    req_op_i       = '0;
    req_tag_i      = '0;
    for (int i = 0; i < N; i++) begin
      req_r0_i[32*i +: 32]         = s_r0[i];
      req_r1_i[32*i +: 32]         = s_r1[i];
      req_pc_i[32*i +: 32]         = s_pc[i];
      req_grand_op_i[2*i +: 2]     = s_gop[i];
      req_op_i[2*i +: 2]           = s_op[i];
      req_tag_i[TAG_W*i +: TAG_W]  = s_tag[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (m_ptr + j) % N;
      if (s_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_can();
    return !s_flush && (!m_valid || s_rready);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_res = '0; m_tag = '0; m_src = 0; last_acc = -1;
    for (int i = 0; i < N; i++) fair_cnt[i] = 0;
  endtask

  // Advance the model by one clock edge using the inputs held during the cycle
  task automatic model_step();
    int k;
    k = model_grant();
    last_acc = -1;
    for (int i = 0; i < N; i++) if (!s_valid[i]) fair_cnt[i] = 0;
    if (k >= 0 && model_can()) begin
      for (int i = 0; i < N; i++) begin
        if (s_valid[i]) begin
          if (i == k) begin
            check("fairness", 32'(fair_cnt[i] < N), 32'd1);
            fair_cnt[i] = 0;
          end else begin
            fair_cnt[i]++;
          end
        end
      end
      m_valid  = 1'b1;
      m_res    = s_r1[k] + s_r0[k];
      m_tag    = s_tag[k];
      m_src    = k;
      m_ptr    = (k + 1) % N;
      last_acc = k;
    end else if (s_flush || s_rready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_flush = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Held requesters keep valid and payload unless accepted or flushed
  task automatic apply_stimulus(input bit was_flush);
    for (int i = 0; i < N; i++) begin
      if (!(s_valid[i] && last_acc != i && !was_flush)) begin
        s_valid[i] = ($urandom_range(0, 99) < 60);
        s_r0[i]    = $urandom;
        s_r1[i]    = $urandom;
        s_pc[i]    = $urandom;
        s_gop[i]   = 2'($urandom);
        s_op[i]    = 2'($urandom);
        s_tag[i]   = TAG_W'($urandom);
        fair_cnt[i] = 0;
      end
    end
    s_flush  = ($urandom_range(0, 99) < 6);
    s_rready = ($urandom_range(0, 99) < 70);
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      cmp_k   = model_grant();
      cmp_sel = (cmp_k >= 0) ? cmp_k : m_ptr;
      cmp_rdy = '0;
      if (cmp_k >= 0 && model_can()) cmp_rdy[cmp_k] = 1'b1;
      check("req_ready", 32'(req_ready_o), 32'(cmp_rdy));
      check("alu_r0", alu_r0_o, s_r0[cmp_sel]);
      check("alu_r1", alu_r1_o, s_r1[cmp_sel]);
      check("alu_pc", alu_pc_o, s_pc[cmp_sel]);
      check("alu_grand_op", 32'(alu_grand_op_o), 32'(s_gop[cmp_sel]));
      check("alu_op", 32'(alu_op_o), 32'(s_op[cmp_sel]));
      check("res_valid", 32'(res_valid_o), 32'(m_valid));
      check("res", res_o, m_res);
      check("res_tag", 32'(res_tag_o), 32'(m_tag));
      check("res_src", 32'(res_src_o), 32'(m_src));
    end
  end

  initial begin
    bit f;
    rst = 1'b1;
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    s_valid = '0; s_flush = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_r0[i]  = 32'hAAAA_0000 + 32'(i);
      s_r1[i]  = 32'hBBBB_0000 + 32'(i);
      s_pc[i]  = 32'h0000_1000 + 32'(4 * i);
      s_gop[i] = 2'(i);
      s_op[i]  = 2'(i + 1);
      s_tag[i] = TAG_W'(i + 1);
    end
    model_reset();
    do_reset();
    chk_en = 1'b1;

    // reset then idle
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_alu_r0", alu_r0_o, 32'hAAAA_0000);

    // single op
    cycle();
    s_valid = 3'b001; s_r0[0] = 32'd3; s_r1[0] = 32'd5; s_gop[0] = 2'b10; s_op[0] = 2'b00;
    s_tag[0] = 6'h11; s_rready = 1'b1;
    @(negedge clk);
    check("single_ready", 32'(req_ready_o), 32'd1);
    cycle();
    s_valid = '0;
    @(negedge clk);
    check("single_valid", 32'(res_valid_o), 32'd1);
    check("single_res", res_o, 32'd8);
    check("single_tag", 32'(res_tag_o), 32'h11);
    check("single_src", 32'(res_src_o), 32'd0);

    // round robin between req0 and req1
    do_reset();
    s_valid = 3'b011; s_r0[0] = 32'd10; s_r1[0] = 32'd20; s_r0[1] = 32'd100; s_r1[1] = 32'd200;
    s_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      @(negedge clk);
      check("rr_src", 32'(res_src_o), 32'(i % 2));
      check("rr_res", res_o, (i % 2) ? 32'd300 : 32'd30);
      check("rr_valid", 32'(res_valid_o), 32'd1);
    end

    // backpressure with req1 waiting; the pending result is req0's
    cycle();
    s_rready = 1'b0; s_valid = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready_o), 32'd0);
      check("bp_res", res_o, 32'd30);
      check("bp_src", 32'(res_src_o), 32'd0);
      cycle();
    end
    s_rready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready_o), 32'b010);
    cycle();
    s_valid = '0; s_rready = 1'b0;
    @(negedge clk);
    check("bp_next_src", 32'(res_src_o), 32'd1);
    check("bp_next_res", res_o, 32'd300);

    // flush with a pending result and req0 valid
    cycle();
    s_valid = 3'b001; s_r0[0] = 32'd40; s_r1[0] = 32'd2; s_flush = 1'b1;
    @(negedge clk);
    check("flush_ready", 32'(req_ready_o), 32'd0);
    cycle();
    s_flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(res_valid_o), 32'd0);
    check("flush_held_res", res_o, 32'd300);
    check("post_flush_ready", 32'(req_ready_o), 32'b001);
    cycle();
    s_valid = '0;
    @(negedge clk);
    check("post_flush_src", 32'(res_src_o), 32'd0);
    check("post_flush_res", res_o, 32'd42);
    check("idle_alu_r0", alu_r0_o, 32'd100);

    // asynchronous reset mid-cycle with a result pending
    cycle();
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(res_valid_o), 32'd0);
    check("arst_res", res_o, 32'd0);
    check("arst_src", 32'(res_src_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    s_valid = 3'b101; s_rready = 1'b1;
    @(negedge clk);
    check("arst_first_grant", 32'(req_ready_o), 32'b001);
    cycle();
    s_valid = '0;
    @(negedge clk);
    check("arst_first_src", 32'(res_src_o), 32'd0);

    // randomized traffic
    last_acc = -1;
    apply_stimulus(1'b1);
    for (int c = 0; c < 800; c++) begin
      f = s_flush;
      cycle();
      apply_stimulus(f);
    end

    s_valid = '0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
